serial_adder: RTL and testbench
===============================

# serial_adder

Parametrised bit-serial adder, the sequential successor to the team's single-bit half/full adder cells. It reuses one full-adder cell over WIDTH clock cycles to add two WIDTH-bit operands plus carry-in, and gives up throughput to save area. A start/busy/done handshake lets a host sequencer issue an operation and collect a registered result. It sits between operand registers and any consumer that tolerates multi-cycle latency.

## Interface

Parameters:
- WIDTH, 8, operand/result width in bits; legal range WIDTH >= 2.

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- rst  input  1  reset, asynchronous, active-high; forces IDLE and clears all registers.
- start  input  1  request; sampled only in IDLE or DONE.
- a  input  WIDTH  operand A; captured on an accepted start.
- b  input  WIDTH  operand B; captured on an accepted start.
- cin  input  1  carry-in; captured on an accepted start.
- busy  output  1  high while in RUN.
- done  output  1  one-cycle pulse marking the cycle in which a new result becomes valid.
- sum  output  WIDTH  registered result; holds its value until the next completion.
- cout  output  1  registered carry-out; holds its value like sum.

## Operation

- The FSM has three states: IDLE, RUN and DONE. Reset enters IDLE.
- In IDLE or DONE, when start=1 at the edge:
  - a and b load into working shift registers, cin loads into the carry flop, and the bit counter clears to 0.
  - The FSM goes to RUN.
- In RUN, on each edge:
  - s = a_sh[0] ^ b_sh[0] ^ c.
  - c <= majority(a_sh[0], b_sh[0], c).
  - a_sh and b_sh shift right by one.
  - s shifts into the MSB of the working sum register.
  - The counter increments.
- When the counter reaches WIDTH-1 and that edge processes the final bit:
  - sum <= the complete working sum; cout <= the final carry.
  - The FSM goes to DONE.
- In DONE with start=0, the FSM goes to IDLE. With start=1 it accepts the new operation (back-to-back).
- start in RUN is ignored and is not queued.
- sum and cout never change during RUN. They change only on the edge that enters DONE.
- The result is a + b + cin modulo 2^WIDTH, and cout is bit WIDTH of the full sum.
- The counter width is $clog2(WIDTH).

## Timing

- Reset values (asynchronous, immediate): state=IDLE, busy=0, done=0, sum=0, cout=0. Working registers and counter = 0.
- Reset asserted mid-RUN aborts the operation.
  - sum and cout go to 0, not to the prior result.
  - No done pulse is generated.
- Acceptance edge E0: the FSM enters RUN and busy=1 in the following cycle.
- Bits 0..WIDTH-1 are processed at edges E1..EWIDTH.
- After EWIDTH: state=DONE, busy=0, done=1, and sum/cout are valid.
- Latency is WIDTH edges from the acceptance edge to done high.
- done is high for exactly one cycle unless a back-to-back start re-enters RUN. In both cases done falls after EWIDTH+1.
- Maximum throughput is one operation per WIDTH+1 cycles.
- Operands may change freely after E0.

## Configuration

- SERIAL_ADDER_SUB_EN defined:
  - Adds the input port sub (1 bit), captured on an accepted start.
  - sub=1 computes a + ~b + 1 (a - b). cin is ignored and the carry flop loads 1.
  - cout=1 means no borrow (a >= b unsigned).
  - sub=0 performs normal addition.
- SERIAL_ADDER_SUB_EN undefined:
  - The sub port does not exist; the block performs addition only, exactly as described above.

## Test plan

All scenarios use WIDTH=8.

- Reset, then start with a=0x00, b=0x00, cin=0 -> busy for 8 cycles, done pulse 8 edges after acceptance, sum=0x00, cout=0.
- a=0xFF, b=0x01, cin=0 -> sum=0x00, cout=1. a=0x5A, b=0xA5, cin=1 -> sum=0x00, cout=1. a=0x3C, b=0x41, cin=0 -> sum=0x7D, cout=0.
- Sum held during RUN:
  - Stimulus: result 0x7D is present; start a=0x01, b=0x01, then pulse start again at RUN cycle 3.
  - Required: sum stays 0x7D throughout RUN, the second start is ignored, and exactly one done pulse occurs with sum=0x02.
- Back-to-back:
  - Stimulus: hold start=1 during the DONE cycle with new operands 0x80+0x80.
  - Required: the FSM re-enters RUN immediately, and the second done arrives WIDTH+1 cycles after the first with sum=0x00, cout=1.
- Reset mid-operation:
  - Stimulus: assert rst asynchronously (mid-cycle) at RUN cycle 4.
  - Required: sum/cout/busy/done go to 0 without waiting for an edge, and no done follows.
  - A subsequent start 0x12+0x34 yields 0x46.
- With SERIAL_ADDER_SUB_EN and sub=1:
  - 0x10-0x01 -> sum=0x0F, cout=1.
  - 0x01-0x02 -> sum=0xFF, cout=0.
  - cin=1 with sub=1 does not change either result.

Source files
------------

// File: rtl/serial_adder.sv
// serial_adder: bit-serial WIDTH-bit adder reusing one full-adder cell over WIDTH cycles.
// Optional SERIAL_ADDER_SUB_EN adds a sub port for a - b via a + ~b + 1.
module serial_adder #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
`ifdef SERIAL_ADDER_SUB_EN
  input  logic             sub,
`endif
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);
  localparam int CW = $clog2(WIDTH);
  localparam logic [1:0] IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2;
  localparam logic [CW-1:0] last_bit = CW'(WIDTH - 1);
  logic [1:0] state;
  logic [WIDTH-1:0] a_sh, b_sh, ws_next;
  logic [WIDTH-2:0] ws;
  logic [CW-1:0] cnt;
  logic c, s, c_next, accept, sub_i;
`ifdef SERIAL_ADDER_SUB_EN
  assign sub_i = sub;
`else
  assign sub_i = 1'b0;
`endif
  always_comb begin
    s       = a_sh[0] ^ b_sh[0] ^ c;
    c_next  = (a_sh[0] & b_sh[0]) | (c & (a_sh[0] ^ b_sh[0]));
    ws_next = {s, ws};
    accept  = start && (state == IDLE || state == DONE);
  end
  assign busy = state == RUN;
  assign done = state == DONE;
  // ws keeps only the WIDTH-1 bits already produced; the final bit joins them on the last edge
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      a_sh  <= '0;
      b_sh  <= '0;
      ws    <= '0;
      c     <= 1'b0;
      cnt   <= '0;
      sum   <= '0;
      cout  <= 1'b0;
    end else if (accept) begin
      a_sh  <= a;
      b_sh  <= sub_i ? ~b : b;
      c     <= sub_i | cin;
      cnt   <= '0;
      state <= RUN;
    end else if (state == RUN) begin
      a_sh <= a_sh >> 1;
      b_sh <= b_sh >> 1;
      c    <= c_next;
      ws   <= ws_next[WIDTH-1:1];
      cnt  <= cnt + 1'b1;
      if (cnt == last_bit) begin
        sum   <= ws_next;
        cout  <= c_next;
        state <= DONE;
      end
    end else if (state == DONE) begin
      state <= IDLE;
    end
  end
endmodule

// File: tb/tb_serial_adder.sv
// tb_serial_adder: directed self-checking bench for serial_adder with WIDTH=8.
module tb_serial_adder;
  logic clk = 1'b0, rst = 1'b1, start = 1'b0, cin = 1'b0, sub = 1'b0;
  logic [7:0] a = '0, b = '0;
  logic busy, done, cout;
  logic [7:0] sum;
  int checks = 0, errors = 0;

  serial_adder #(.WIDTH(8)) dut (
    .clk(clk), .rst(rst), .start(start), .a(a), .b(b), .cin(cin),
`ifdef SERIAL_ADDER_SUB_EN
    .sub(sub),
`endif
    .busy(busy), .done(done), .sum(sum), .cout(cout)
  );

  always #5 clk = ~clk;

  task automatic issue(input logic [7:0] ai, input logic [7:0] bi, input logic ci, input logic si);
    a = ai; b = bi; cin = ci; sub = si; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  task automatic test_reset;
    #2;
    checks++;
    if ({busy, done, cout, sum} !== 11'd0) begin
      errors++;
      $display("FAIL reset: busy=%b done=%b sum=%h cout=%b, expected all zero", busy, done, sum, cout);
    end
    @(negedge clk) rst = 1'b0;
  endtask

  task automatic test_add;
    logic [7:0] va [4] = '{8'h00, 8'hFF, 8'h5A, 8'h3C};
    logic [7:0] vb [4] = '{8'h00, 8'h01, 8'hA5, 8'h41};
    logic       vc [4] = '{1'b0, 1'b0, 1'b1, 1'b0};
    logic [7:0] es [4] = '{8'h00, 8'h00, 8'h00, 8'h7D};
    logic       ec [4] = '{1'b0, 1'b1, 1'b1, 1'b0};
    logic [7:0] prev;
    for (int i = 0; i < 4; i++) begin
      prev = sum;
      issue(va[i], vb[i], vc[i], 1'b0);
      for (int k = 1; k <= 9; k++) begin
        @(negedge clk);
        checks++;
        if (k < 9 && (busy !== 1'b1 || done !== 1'b0 || sum !== prev)) begin
          errors++;
          $display("FAIL add%0d run k=%0d: busy=%b done=%b sum=%h, expected busy=1 done=0 sum=%h", i, k, busy, done, sum, prev);
        end
        if (k == 9 && (busy !== 1'b0 || done !== 1'b1 || sum !== es[i] || cout !== ec[i])) begin
          errors++;
          $display("FAIL add%0d done: busy=%b done=%b sum=%h cout=%b, expected 0 1 %h %b", i, busy, done, sum, cout, es[i], ec[i]);
        end
      end
      @(negedge clk);
      checks++;
      if (busy !== 1'b0 || done !== 1'b0) begin
        errors++;
        $display("FAIL add%0d idle: busy=%b done=%b, expected 0 0", i, busy, done);
      end
    end
  endtask

  task automatic test_hold;
    int pulses = 0;
    issue(8'h01, 8'h01, 1'b0, 1'b0);
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
      if (done === 1'b1) pulses++;
      start = (k == 3);
      checks++;
      if (k < 9 && (sum !== 8'h7D || busy !== 1'b1)) begin
        errors++;
        $display("FAIL hold k=%0d: sum=%h busy=%b, expected 7d 1", k, sum, busy);
      end
      if (k == 9 && (done !== 1'b1 || sum !== 8'h02 || cout !== 1'b0)) begin
        errors++;
        $display("FAIL hold done: done=%b sum=%h cout=%b, expected 1 02 0", done, sum, cout);
      end
      if (k > 9 && (done !== 1'b0 || busy !== 1'b0)) begin
        errors++;
        $display("FAIL hold after k=%0d: done=%b busy=%b, expected 0 0", k, done, busy);
      end
    end
    checks++;
    if (pulses != 1) begin
      errors++;
      $display("FAIL hold pulses: got %0d, expected 1", pulses);
    end
  endtask

  task automatic test_back_to_back;
    int done_at = 0;
    issue(8'h11, 8'h22, 1'b0, 1'b0);
    repeat (9) @(negedge clk);
    checks++;
    if (done !== 1'b1 || sum !== 8'h33) begin
      errors++;
      $display("FAIL b2b first: done=%b sum=%h, expected 1 33", done, sum);
    end
    issue(8'h80, 8'h80, 1'b0, 1'b0);
    for (int k = 1; k <= 20 && done_at == 0; k++) begin
      @(negedge clk);
      if (k == 1) begin
        checks++;
        if (busy !== 1'b1 || done !== 1'b0) begin
          errors++;
          $display("FAIL b2b rerun: busy=%b done=%b, expected 1 0", busy, done);
        end
      end
      if (done === 1'b1) done_at = k;
    end
    checks++;
    if (done_at != 9 || sum !== 8'h00 || cout !== 1'b1) begin
      errors++;
      $display("FAIL b2b second: done after %0d cycles sum=%h cout=%b, expected 9 00 1", done_at, sum, cout);
    end
    @(negedge clk);
  endtask

  task automatic test_sub;
    logic [7:0] va [4] = '{8'h10, 8'h01, 8'h10, 8'h01};
    logic [7:0] vb [4] = '{8'h01, 8'h02, 8'h01, 8'h02};
    logic       vc [4] = '{1'b0, 1'b0, 1'b1, 1'b1};
    logic [7:0] es [4] = '{8'h0F, 8'hFF, 8'h0F, 8'hFF};
    logic       ec [4] = '{1'b1, 1'b0, 1'b1, 1'b0};
    for (int i = 0; i < 4; i++) begin
      issue(va[i], vb[i], vc[i], 1'b1);
      repeat (9) @(negedge clk);
      checks++;
      if (done !== 1'b1 || sum !== es[i] || cout !== ec[i]) begin
        errors++;
        $display("FAIL sub%0d: done=%b sum=%h cout=%b, expected 1 %h %b", i, done, sum, cout, es[i], ec[i]);
      end
      @(negedge clk);
    end
    sub = 1'b0;
  endtask

  task automatic test_reset_mid;
    int pulses = 0;
    issue(8'hF0, 8'h20, 1'b0, 1'b0);
    repeat (9) @(negedge clk);
    checks++;
    if (sum !== 8'h10 || cout !== 1'b1) begin
      errors++;
      $display("FAIL midrst pre: sum=%h cout=%b, expected 10 1", sum, cout);
    end
    @(negedge clk);
    issue(8'h0F, 8'h01, 1'b0, 1'b0);
    repeat (4) @(negedge clk);
    @(posedge clk);
    #3 rst = 1'b1;
    #1;
    checks++;
    if ({busy, done, cout, sum} !== 11'd0) begin
      errors++;
      $display("FAIL midrst async: busy=%b done=%b sum=%h cout=%b, expected all zero", busy, done, sum, cout);
    end
    @(negedge clk) rst = 1'b0;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      if (done === 1'b1 || busy === 1'b1) pulses++;
    end
    checks++;
    if (pulses != 0) begin
      errors++;
      $display("FAIL midrst quiet: %0d busy/done cycles, expected 0", pulses);
    end
    issue(8'h12, 8'h34, 1'b0, 1'b0);
    repeat (9) @(negedge clk);
    checks++;
    if (done !== 1'b1 || sum !== 8'h46 || cout !== 1'b0) begin
      errors++;
      $display("FAIL midrst after: done=%b sum=%h cout=%b, expected 1 46 0", done, sum, cout);
    end
  endtask

  initial begin
    test_reset;
    test_add;
    test_hold;
    test_back_to_back;
`ifdef SERIAL_ADDER_SUB_EN
    test_sub;
`endif
    test_reset_mid;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
